mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between instruction fetch (IF) and data load/store (D) requesters.
- Sequences each transaction: grant, issue, optional read-response wait, return.
- One transaction outstanding at a time.
- Drives a stall to the PC/datapath while the port is busy.
- Aborts hung transactions with a watchdog.

---
 rtl/mem_port_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store, one transaction at a time.
// Optional: define ARB_ROUND_ROBIN_EN to alternate the winner on simultaneous requests (default: data always wins).
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall,
    output logic                err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP} state_e;
    typedef enum logic {OWN_IF, OWN_D} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                err_q, err_d;
    logic                if_gnt_c, d_gnt_c, d_win, done, expire;
`ifdef ARB_ROUND_ROBIN_EN
    owner_e              prio_q, prio_d;
`endif

`ifdef ARB_ROUND_ROBIN_EN
    // prio_q names the requester that wins a tie; it flips to the other side on every grant.
    assign d_win = d_req && (!if_req || prio_q == OWN_D);
`else
    assign d_win = d_req;
`endif

    assign expire = (cnt_q == CNT_W'(MAX_WAIT - 1));

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        err_d       = 1'b0;
        if_gnt_c    = 1'b0;
        d_gnt_c     = 1'b0;
        done        = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        prio_d      = prio_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (d_win) begin
                    d_gnt_c     = 1'b1;
                    owner_d     = OWN_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
                    state_d     = S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    prio_d      = OWN_IF;
`endif
                end else if (if_req) begin
                    if_gnt_c    = 1'b1;
                    owner_d     = OWN_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    cnt_d       = '0;
                    state_d     = S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    prio_d      = OWN_D;
`endif
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        done       = 1'b1;
                        state_d    = S_IDLE;
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = '0;
                    end else begin
                        state_d = S_WAIT_RSP;
                    end
                end
            end
            S_WAIT_RSP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A completion in the expiry cycle takes precedence over the abort.
        if (state_q != S_IDLE && !done && expire) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            if (owner_q == OWN_IF) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = '0;
            end else begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = '0;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_q      <= OWN_D;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            prio_q      <= prio_d;
`endif
        end
    end

    // Grants are masked during reset so every output reads 0 while it is held.
    assign if_gnt    = if_gnt_c & ~reset;
    assign d_gnt     = d_gnt_c & ~reset;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall     = (state_q != S_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after posedge, outputs are sampled at negedge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall, err;

    int checks = 0;
    int errors = 0;
    logic exp_d_win;
    logic prev_req;
    logic [31:0] prev_addr;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
        d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        sample();
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        next_cycle();
        reset = 1'b0;

        // Single fetch with minimum latency.
        if_req = 1; if_addr = 32'h100; mem_ready = 1;
        sample();
        check("f_gnt", 64'(if_gnt), 64'd1);
        check("f_stall_T", 64'(stall), 64'd0);
        next_cycle(); if_req = 0;
        sample();
        check("f_mem_req", 64'(mem_req), 64'd1);
        check("f_mem_addr", 64'(mem_addr), 64'h100);
        check("f_mem_we", 64'(mem_we), 64'd0);
        check("f_mem_be", 64'(mem_be), 64'hF);
        check("f_stall_T1", 64'(stall), 64'd1);
        next_cycle(); mem_rvalid = 1; mem_rdata = 32'h0050_0093;
        sample();
        check("f_stall_T2", 64'(stall), 64'd1);
        check("f_req_drop", 64'(mem_req), 64'd0);
        next_cycle(); mem_rvalid = 0;
        sample();
        check("f_rvalid", 64'(if_rvalid), 64'd1);
        check("f_rdata", 64'(if_rdata), 64'h0050_0093);
        check("f_stall_T3", 64'(stall), 64'd0);
        next_cycle();
        sample();
        check("f_rvalid_pulse", 64'(if_rvalid), 64'd0);
        check("f_rdata_hold", 64'(if_rdata), 64'h0050_0093);

        // Simultaneous requests: data first, then the still-pending fetch.
        next_cycle();
        if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200;
        sample();
        check("c_d_gnt", 64'(d_gnt), 64'd1);
        check("c_if_gnt0", 64'(if_gnt), 64'd0);
        next_cycle(); d_req = 0;
        sample();
        check("c_mem_addr_d", 64'(mem_addr), 64'h200);
        next_cycle(); mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        sample();
        check("c_if_gnt_busy", 64'(if_gnt), 64'd0);
        next_cycle(); mem_rvalid = 0;
        sample();
        check("c_d_rvalid", 64'(d_rvalid), 64'd1);
        check("c_d_rdata", 64'(d_rdata), 64'h1111_2222);
        check("c_if_gnt_T3", 64'(if_gnt), 64'd1);
        next_cycle(); if_req = 0;
        sample();
        check("c_mem_addr_if", 64'(mem_addr), 64'h104);
        next_cycle(); mem_rvalid = 1; mem_rdata = 32'h3333_4444;
        sample();
        next_cycle(); mem_rvalid = 0;
        sample();
        check("c_if_rvalid", 64'(if_rvalid), 64'd1);
        check("c_if_rdata", 64'(if_rdata), 64'h3333_4444);
        check("c_d_rdata_hold", 64'(d_rdata), 64'h1111_2222);

        // Store with mem_ready delayed three cycles.
        next_cycle();
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h300; d_wdata = 32'hDEAD_BEEF; mem_ready = 0;
        sample();
        check("s_gnt", 64'(d_gnt), 64'd1);
        next_cycle(); d_req = 0; d_we = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1;
            sample();
            check("s_mem_req", 64'(mem_req), 64'd1);
            check("s_mem_we", 64'(mem_we), 64'd1);
            check("s_mem_be", 64'(mem_be), 64'h3);
            check("s_mem_addr", 64'(mem_addr), 64'h300);
            check("s_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
            next_cycle();
        end
        mem_ready = 0;
        sample();
        check("s_rvalid", 64'(d_rvalid), 64'd1);
        check("s_rdata_zero", 64'(d_rdata), 64'd0);
        check("s_no_wait", 64'(stall), 64'd0);
        check("s_mem_req_low", 64'(mem_req), 64'd0);

        // Conflict right after a data grant: round robin hands it to fetch.
        exp_d_win = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_d_win = 1'b0;
`endif
        next_cycle();
        if_req = 1; if_addr = 32'h108; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h204; mem_ready = 1;
        sample();
        check("rr_d_gnt", 64'(d_gnt), 64'(exp_d_win));
        check("rr_if_gnt", 64'(if_gnt), 64'(!exp_d_win));
        next_cycle(); if_req = 0; d_req = 0;
        sample();
        check("rr_mem_addr", 64'(mem_addr), exp_d_win ? 64'h204 : 64'h108);
        next_cycle(); mem_rvalid = 1; mem_rdata = 32'h0000_CAFE;
        sample();
        next_cycle(); mem_rvalid = 0;
        sample();
        check("rr_d_rvalid", 64'(d_rvalid), 64'(exp_d_win));
        check("rr_if_rvalid", 64'(if_rvalid), 64'(!exp_d_win));

        // Watchdog: mem_ready never comes.
        next_cycle();
        if_req = 1; if_addr = 32'h400; mem_ready = 0;
        sample();
        check("w_gnt", 64'(if_gnt), 64'd1);
        next_cycle(); if_req = 0;
        for (int i = 0; i < 15; i++) begin
            sample();
            check("w_err_early", 64'(err), 64'd0);
            check("w_mem_req_held", 64'(mem_req), 64'd1);
            next_cycle();
        end
        if_req = 1; if_addr = 32'h500; mem_ready = 1;
        sample();
        check("w_err", 64'(err), 64'd1);
        check("w_if_rvalid", 64'(if_rvalid), 64'd1);
        check("w_if_rdata0", 64'(if_rdata), 64'd0);
        check("w_mem_req_low", 64'(mem_req), 64'd0);
        check("w_stall_low", 64'(stall), 64'd0);
        check("w_next_gnt", 64'(if_gnt), 64'd1);
        next_cycle(); if_req = 0;
        sample();
        check("w_err_pulse", 64'(err), 64'd0);
        check("w_next_addr", 64'(mem_addr), 64'h500);
        next_cycle(); mem_rvalid = 1; mem_rdata = 32'h0000_ABCD;
        sample();
        next_cycle(); mem_rvalid = 0;
        sample();
        check("w_next_rvalid", 64'(if_rvalid), 64'd1);
        check("w_next_rdata", 64'(if_rdata), 64'h0000_ABCD);

        // Reset while waiting for a read response.
        next_cycle();
        d_req = 1; d_we = 0; d_addr = 32'h600;
        sample();
        check("r_gnt", 64'(d_gnt), 64'd1);
        next_cycle(); d_req = 0;
        sample();
        next_cycle();
        sample();
        check("r_in_wait", 64'(stall), 64'd1);
        next_cycle();
        reset = 1'b1;
        #1;
        check("r_stall", 64'(stall), 64'd0);
        check("r_mem_req", 64'(mem_req), 64'd0);
        check("r_mem_we", 64'(mem_we), 64'd0);
        check("r_mem_be", 64'(mem_be), 64'd0);
        check("r_mem_addr", 64'(mem_addr), 64'd0);
        check("r_mem_wdata", 64'(mem_wdata), 64'd0);
        check("r_err", 64'(err), 64'd0);
        check("r_if_rdata", 64'(if_rdata), 64'd0);
        check("r_d_rvalid", 64'(d_rvalid), 64'd0);
        check("r_d_gnt", 64'(d_gnt), 64'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("r_late_d_rvalid", 64'(d_rvalid), 64'd0);
            check("r_late_if_rvalid", 64'(if_rvalid), 64'd0);
            check("r_late_d_rdata", 64'(d_rdata), 64'd0);
            next_cycle();
        end
        mem_rvalid = 0;

        // Back-to-back fetches with a responder returning data one cycle after ready.
        prev_req = 0; prev_addr = 0; mem_ready = 1;
        for (int k = 0; k <= 12; k++) begin
            if_req = 1;
            if (k % 3 == 0) if_addr = 32'h1000 + 32'(4 * (k / 3));
            mem_rvalid = prev_req;
            mem_rdata = 32'hF000_0000 | prev_addr;
            sample();
            check("b_gnt", 64'(if_gnt), 64'(k % 3 == 0));
            check("b_rvalid", 64'(if_rvalid), 64'(k % 3 == 0 && k > 0));
            if (k % 3 == 0 && k > 0)
                check("b_rdata", 64'(if_rdata), 64'(32'hF000_1000 + 32'(4 * (k / 3 - 1))));
            prev_req = mem_req;
            prev_addr = mem_addr;
            next_cycle();
        end
        if_req = 0; mem_rvalid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
